// File: rtl/ingress_serializer.sv
// Serialises one retirement bundle into per-uop trace emissions, folding STD runs into a retire count.
// Zero latency (outputs combinational from idx_q and the held bundle); with ready_i low every output holds.
package mure_pkg;
    typedef enum logic [2:0] {
        STD  = 3'd0,
        EXC  = 3'd1,
        INT  = 3'd2,
        ERET = 3'd3
    } itype_e;

    typedef struct packed {
        itype_e      itype;
        logic [31:0] pc;
        logic [7:0]  tag;
    } uop_entry_s;

    function automatic logic is_trap(itype_e t);
        return (t == EXC) || (t == INT) || (t == ERET);
    endfunction
endpackage

module ingress_serializer #(
    parameter int unsigned NR_RET   = 4,
    parameter bit          COMPRESS = 1'b1,
    parameter int unsigned CNT_W    = $clog2(NR_RET) + 1
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic                                bundle_valid_i,
    input  logic [NR_RET-1:0]                   ivalids_i,
    input  mure_pkg::uop_entry_s [NR_RET-1:0]   uops_i,
    output logic                                pop_o,
    output logic                                valid_o,
    output mure_pkg::uop_entry_s                uop_o,
    output logic [CNT_W-1:0]                    iretire_o,
    input  logic                                ready_i
);
    localparam int unsigned IDX_W = $clog2(NR_RET);

    typedef enum logic {
        SCAN  = 1'b0,
        DRAIN = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;

    logic [NR_RET-1:0]  emit;
    logic               higher_vld;
    logic               higher_trap;
    logic               found;
    logic               more;
    logic [IDX_W-1:0]   target;
    logic [CNT_W-1:0]   skipped;
    logic               accept;

    // Walk downward so each slot knows whether a younger valid slot exists and whether it is a trap.
    always_comb begin
        emit        = '0;
        higher_vld  = 1'b0;
        higher_trap = 1'b0;
        for (int k = NR_RET - 1; k >= 0; k--) begin
            if (ivalids_i[k]) begin
                emit[k]     = !COMPRESS || (uops_i[k].itype != mure_pkg::STD) ||
                              !higher_vld || higher_trap;
                higher_vld  = 1'b1;
                higher_trap = mure_pkg::is_trap(uops_i[k].itype);
            end
        end
    end

    always_comb begin
        found   = 1'b0;
        more    = 1'b0;
        target  = '0;
        skipped = '0;
        for (int k = 0; k < NR_RET; k++) begin
            if (k >= int'(idx_q)) begin
                if (found) begin
                    if (emit[k]) more = 1'b1;
                end else if (emit[k]) begin
                    found  = 1'b1;
                    target = IDX_W'(k);
                end else if (ivalids_i[k]) begin
                    skipped = skipped + CNT_W'(1);
                end
            end
        end
    end

    assign accept = bundle_valid_i && found && ready_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= SCAN;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = SCAN;
        idx_d   = idx_q;
        case (state_q)
            SCAN: begin
                if (accept) idx_d = more ? (target + IDX_W'(1)) : '0;
            end
            default: idx_d = '0;
        endcase
    end

    // Outputs are forced to their reset values while rst_ni is low so reset acts on them asynchronously.
    always_comb begin
        valid_o   = 1'b0;
        pop_o     = 1'b0;
        uop_o     = '0;
        iretire_o = '0;
        if (rst_ni && (state_q == SCAN) && bundle_valid_i) begin
            if (found) begin
                valid_o   = 1'b1;
                uop_o     = uops_i[target];
                iretire_o = skipped + CNT_W'(1);
                pop_o     = ready_i && !more;
            end else begin
                pop_o     = 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_ingress_serializer.sv
// Randomised and directed bench for ingress_serializer, one instance per COMPRESS setting,
// checked against a run-folding model of the retirement bundle.
module tb_ingress_serializer;
    import mure_pkg::*;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  bv;
    logic [3:0]            iv;
    uop_entry_s [3:0]      uops;
    logic                  ready;
    logic                  sel_c;

    logic                  pop_c, vld_c, pop_n, vld_n;
    uop_entry_s            uop_c, uop_n;
    logic [2:0]            cnt_c, cnt_n;

    logic                  obs_pop, obs_vld;
    uop_entry_s            obs_uop;
    logic [2:0]            obs_cnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ingress_serializer #(.NR_RET(4), .COMPRESS(1'b1)) u_dut_c (
        .clk_i(clk), .rst_ni(rst_n), .bundle_valid_i(bv), .ivalids_i(iv), .uops_i(uops),
        .pop_o(pop_c), .valid_o(vld_c), .uop_o(uop_c), .iretire_o(cnt_c),
        .ready_i(ready && sel_c)
    );

    ingress_serializer #(.NR_RET(4), .COMPRESS(1'b0)) u_dut_n (
        .clk_i(clk), .rst_ni(rst_n), .bundle_valid_i(bv), .ivalids_i(iv), .uops_i(uops),
        .pop_o(pop_n), .valid_o(vld_n), .uop_o(uop_n), .iretire_o(cnt_n),
        .ready_i(ready && !sel_c)
    );

    assign obs_pop = sel_c ? pop_c : pop_n;
    assign obs_vld = sel_c ? vld_c : vld_n;
    assign obs_uop = sel_c ? uop_c : uop_n;
    assign obs_cnt = sel_c ? cnt_c : cnt_n;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic uop_entry_s mk(input itype_e t);
        uop_entry_s u;
        u.itype = t;
        u.pc    = $urandom;
        u.tag   = 8'($urandom);
        return u;
    endfunction

    typedef struct {
        int slot;
        int cnt;
    } exp_t;

    // Entered and left at posedge+1; stalls are cycles with ready low before each accept.
    task automatic run_bundle(input bit cmp, input logic [3:0] v, input uop_entry_s [3:0] u,
                              input int st_lo, input int st_hi);
        exp_t q[$];
        int   pend = 0;
        for (int s = 0; s < 4; s++) begin
            if (v[s]) begin
                int nxt = -1;
                pend++;
                for (int t = s + 1; t < 4; t++)
                    if (v[t] && nxt < 0) nxt = t;
                if (!cmp || u[s].itype != STD || nxt < 0 || is_trap(u[nxt].itype)) begin
                    q.push_back('{slot: s, cnt: pend});
                    pend = 0;
                end
            end
        end
        sel_c = cmp;
        bv    = 1'b1;
        iv    = v;
        uops  = u;
        if (q.size() == 0) begin
            ready = 1'($urandom);
            @(negedge clk);
            chk("empty_pop", 64'(obs_pop), 64'd1);
            chk("empty_vld", 64'(obs_vld), 64'd0);
            @(posedge clk); #1;
        end
        for (int e = 0; e < q.size(); e++) begin
            int  st   = $urandom_range(st_lo, st_hi);
            bit  last = (e == q.size() - 1);
            for (int s = 0; s < st; s++) begin
                ready = 1'b0;
                @(negedge clk);
                chk("hold_vld", 64'(obs_vld), 64'd1);
                chk("hold_uop", 64'(obs_uop), 64'(u[q[e].slot]));
                chk("hold_cnt", 64'(obs_cnt), 64'(q[e].cnt));
                chk("hold_pop", 64'(obs_pop), 64'd0);
                @(posedge clk); #1;
            end
            ready = 1'b1;
            @(negedge clk);
            chk("vld", 64'(obs_vld), 64'd1);
            chk("uop", 64'(obs_uop), 64'(u[q[e].slot]));
            chk("cnt", 64'(obs_cnt), 64'(q[e].cnt));
            chk("pop", 64'(obs_pop), 64'(last));
            @(posedge clk); #1;
        end
        bv    = 1'b0;
        ready = 1'b0;
    endtask

    initial begin
        uop_entry_s [3:0] u;
        rst_n = 1'b0;
        sel_c = 1'b1;
        ready = 1'b1;
        bv    = 1'b1;
        iv    = 4'b1111;
        for (int s = 0; s < 4; s++) uops[s] = mk(STD);
        #3;
        chk("rst_vld", 64'(obs_vld), 64'd0);
        chk("rst_pop", 64'(obs_pop), 64'd0);
        chk("rst_uop", 64'(obs_uop), 64'd0);
        chk("rst_cnt", 64'(obs_cnt), 64'd0);
        ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        bv = 1'b0;

        // No bundle: nothing happens.
        ready = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk("idle_vld", 64'(obs_vld), 64'd0);
            chk("idle_pop", 64'(obs_pop), 64'd0);
            @(posedge clk); #1;
        end
        ready = 1'b0;

        for (int s = 0; s < 4; s++) u[s] = mk(STD);
        run_bundle(1'b1, 4'b1111, u, 0, 0);
        run_bundle(1'b0, 4'b1111, u, 0, 0);

        u[0] = mk(STD); u[1] = mk(STD); u[2] = mk(EXC); u[3] = mk(STD);
        run_bundle(1'b1, 4'b1111, u, 0, 0);

        for (int s = 0; s < 4; s++) u[s] = mk(STD);
        run_bundle(1'b1, 4'b1010, u, 3, 3);

        run_bundle(1'b1, 4'b0000, u, 0, 0);
        u[0] = mk(ERET);
        run_bundle(1'b1, 4'b0001, u, 0, 0);

        // Reset after the second accept; the held bundle must restart at slot 0.
        for (int s = 0; s < 4; s++) u[s] = mk(STD);
        sel_c = 1'b0;
        bv    = 1'b1;
        iv    = 4'b1111;
        uops  = u;
        ready = 1'b1;
        for (int e = 0; e < 2; e++) begin
            @(negedge clk);
            chk("pre_rst_uop", 64'(obs_uop), 64'(u[e]));
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #1;
        chk("arst_vld", 64'(obs_vld), 64'd0);
        chk("arst_pop", 64'(obs_pop), 64'd0);
        chk("arst_uop", 64'(obs_uop), 64'd0);
        chk("arst_cnt", 64'(obs_cnt), 64'd0);
        ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_bundle(1'b0, 4'b1111, u, 0, 0);

        for (int n = 0; n < 300; n++) begin
            logic [3:0] v = 4'($urandom);
            for (int s = 0; s < 4; s++) begin
                int r = $urandom_range(0, 5);
                u[s] = mk(r < 3 ? STD : itype_e'(r - 2));
            end
            run_bundle(1'($urandom), v, u, 0, 2);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
